rr_arbiter: RTL and testbench

- Parametrised round-robin arbiter. Successor to the 4-input combinational fixed-priority (lowest-bit-wins) arbiter.
- Adds:
  - N requesters.
  - A registered, held grant.
  - A rotating priority pointer for fairness.
  - An optional maximum-hold timeout.
- Sits between N request sources and one shared resource (bus, UART, LED driver). Top-level wrappers bind REQ/GNT to board pins.

---
 rtl/rr_arbiter.sv | 63 ++++++
 tb/tb_rr_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way round-robin arbiter with registered held grant and optional max-hold timeout
module rr_arbiter #(
  parameter int N = 4,
  parameter int MAX_HOLD = 0,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           CLK,
  input  logic           RESETN,
  input  logic [N-1:0]   REQ,
  output logic [N-1:0]   GNT,
  output logic           GNT_VALID,
  output logic [IDW-1:0] GNT_ID
);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gid_q, gid_d, ptr_q, ptr_d, nxt;
  logic           vld_q, vld_d, rel, adv;
  logic [HW-1:0]  hcnt_q, hcnt_d;
  logic [IDW:0]   p;
  // {found, index} of the first set bit of v scanning circularly from s; descending scan so the nearest hit wins
  function automatic logic [IDW:0] pick(input logic [N-1:0] v, input logic [IDW-1:0] s);
    logic [IDW:0] r;
    int j;
    r = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(s) + k;
      if (j >= N) j -= N;
      if (v[j]) r = {1'b1, IDW'(j)};
    end
    return r;
  endfunction
  // next-state: hold the current grant until release, then search from the holder's successor so it comes last
  always_comb begin
    nxt    = (gid_q == IDW'(N - 1)) ? '0 : gid_q + 1'b1;
    rel    = !REQ[gid_q] || (MAX_HOLD != 0 && hcnt_q == HW'(MAX_HOLD - 1));
    adv    = !vld_q || rel;
    p      = pick(REQ, vld_q ? nxt : ptr_q);
    gnt_d  = adv ? (p[IDW] ? N'(1) << p[IDW-1:0] : '0) : gnt_q;
    gid_d  = adv ? (p[IDW] ? p[IDW-1:0] : '0) : gid_q;
    vld_d  = adv ? p[IDW] : vld_q;
    ptr_d  = (vld_q && rel) ? nxt : ptr_q;
    hcnt_d = (adv || MAX_HOLD == 0) ? '0 : hcnt_q + 1'b1;
  end
  // state registers; reset drops any grant immediately
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      gnt_q  <= '0;
      gid_q  <= '0;
      vld_q  <= 1'b0;
      ptr_q  <= '0;
      hcnt_q <= '0;
    end else begin
      gnt_q  <= gnt_d;
      gid_q  <= gid_d;
      vld_q  <= vld_d;
      ptr_q  <= ptr_d;
      hcnt_q <= hcnt_d;
    end
  end
  assign GNT       = gnt_q;
  assign GNT_VALID = vld_q;
  assign GNT_ID    = gid_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: vector-table and scoreboard bench over four arbiter configurations
module tb_rr_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] g0, g1, g2;
  logic [2:0] g3;
  logic       v0, v1, v2, v3;
  logic [1:0] i0, i1, i2, i3;
  rr_arbiter #(.N(4), .MAX_HOLD(0)) u0 (.CLK(clk), .RESETN(rst_n), .REQ(req),      .GNT(g0), .GNT_VALID(v0), .GNT_ID(i0));
  rr_arbiter #(.N(4), .MAX_HOLD(4)) u1 (.CLK(clk), .RESETN(rst_n), .REQ(req),      .GNT(g1), .GNT_VALID(v1), .GNT_ID(i1));
  rr_arbiter #(.N(4), .MAX_HOLD(3)) u2 (.CLK(clk), .RESETN(rst_n), .REQ(req),      .GNT(g2), .GNT_VALID(v2), .GNT_ID(i2));
  rr_arbiter #(.N(3), .MAX_HOLD(0)) u3 (.CLK(clk), .RESETN(rst_n), .REQ(req[2:0]), .GNT(g3), .GNT_VALID(v3), .GNT_ID(i3));
  typedef struct {
    int         dut;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    string      name;
  } vec_t;
  typedef struct {
    int         dut;
    logic [3:0] gnt;
    logic [1:0] id;
    string      name;
  } exp_t;
  vec_t vecs[$];
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  task automatic add(input int dut, input logic r, input logic [3:0] rq, input logic [3:0] g, input string name);
    vec_t v;
    v.dut = dut; v.rst_n = r; v.req = rq; v.gnt = g; v.name = name;
    vecs.push_back(v);
  endtask
  task automatic expect_out(input int dut, input logic [3:0] g, input string name);
    exp_t e;
    e.dut = dut; e.gnt = g; e.id = '0; e.name = name;
    for (int b = 0; b < 4; b++) if (g[b]) e.id = 2'(b);
    sb.push_back(e);
  endtask
  task automatic check_one();
    exp_t e;
    logic [3:0] ag;
    logic       av;
    logic [1:0] ai;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    case (e.dut)
      0:       begin ag = g0;          av = v0; ai = i0; end
      1:       begin ag = g1;          av = v1; ai = i1; end
      2:       begin ag = g2;          av = v2; ai = i2; end
      default: begin ag = {1'b0, g3};  av = v3; ai = i3; end
    endcase
    if (ag !== e.gnt) begin
      n_fail++;
      $display("FAIL %s gnt (dut%0d): got %b want %b", e.name, e.dut, ag, e.gnt);
    end
    n_chk++;
    if (av !== (e.gnt != 0)) begin
      n_fail++;
      $display("FAIL %s valid (dut%0d): got %b want %b", e.name, e.dut, av, e.gnt != 0);
    end
    n_chk++;
    if (ai !== e.id) begin
      n_fail++;
      $display("FAIL %s id (dut%0d): got %0d want %0d", e.name, e.dut, ai, e.id);
    end
  endtask
  initial begin
    add(0, 0, 4'b0000, 4'b0000, "A_rst");
    add(0, 0, 4'b0000, 4'b0000, "A_rst2");
    add(0, 1, 4'b0100, 4'b0100, "A_first");
    add(0, 1, 4'b0100, 4'b0100, "A_hold");
    add(0, 1, 4'b0000, 4'b0000, "A_drop");
    add(0, 1, 4'b1001, 4'b1000, "A_ptr3");
    add(0, 1, 4'b0000, 4'b0000, "A_drop2");
    add(0, 1, 4'b1111, 4'b0001, "RR_0");
    add(0, 1, 4'b1110, 4'b0010, "RR_1");
    add(0, 1, 4'b1101, 4'b0100, "RR_2");
    add(0, 1, 4'b1011, 4'b1000, "RR_3");
    add(0, 1, 4'b0111, 4'b0001, "RR_4");
    add(0, 1, 4'b0000, 4'b0000, "RR_end");
    add(1, 0, 4'b0000, 4'b0000, "TO_rst");
    for (int k = 0; k < 9; k++) add(1, 1, 4'b0011, (k >= 4 && k < 8) ? 4'b0010 : 4'b0001, $sformatf("TO_%0d", k));
    add(2, 0, 4'b0000, 4'b0000, "SOLE_rst");
    for (int k = 0; k < 7; k++) add(2, 1, 4'b1000, 4'b1000, $sformatf("SOLE_%0d", k));
    add(2, 1, 4'b1001, 4'b1000, "SOLE_h0");
    add(2, 1, 4'b1001, 4'b1000, "SOLE_h1");
    add(2, 1, 4'b1001, 4'b0001, "SOLE_pass");
    add(3, 0, 4'b0000, 4'b0000, "N3_rst");
    add(3, 1, 4'b0100, 4'b0100, "N3_g2");
    add(3, 1, 4'b0011, 4'b0001, "N3_wrap");
    add(3, 1, 4'b0010, 4'b0010, "N3_g1");
    add(3, 1, 4'b0101, 4'b0100, "N3_g2b");
    add(3, 1, 4'b0000, 4'b0000, "N3_idle");
    foreach (vecs[i]) begin
      @(negedge clk);
      if (i > 0) check_one();
      rst_n = vecs[i].rst_n;
      req = vecs[i].req;
      expect_out(vecs[i].dut, vecs[i].gnt, vecs[i].name);
    end
    @(negedge clk);
    check_one();
    rst_n = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0010;
    expect_out(0, 4'b0010, "AR_grant");
    @(negedge clk);
    check_one();
    expect_out(0, 4'b0010, "AR_held");
    @(negedge clk);
    check_one();
    #2 rst_n = 1'b0;
    expect_out(0, 4'b0000, "AR_async");
    #1 check_one();
    rst_n = 1'b1;
    req = 4'b1110;
    expect_out(0, 4'b0010, "AR_after");
    @(negedge clk);
    check_one();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
